// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction execution stage: opcode encodings
// (also used by the LCD controller's opcode string table), instruction field
// positions, FSM state encodings, the default LCD hold-off length and small
// arithmetic helpers.
package cpu_pkg;

  localparam int unsigned HOLDOFF_DEFAULT = 2_000_000;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SUBI  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_DPL   = 3'b111;

  localparam int OPC_MSB   = 17;
  localparam int OPC_LSB   = 15;
  localparam int RD_MSB    = 14;
  localparam int RD_LSB    = 11;
  localparam int RS_MSB    = 10;
  localparam int RS_LSB    = 7;
  localparam int RT_MSB    = 6;
  localparam int RT_LSB    = 3;
  localparam int IMM7_MSB  = 6;
  localparam int IMM11_MSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WB      = 3'd3,
    ST_NOTIFY  = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_t;

  // Sign-extend a 16-bit register value to the common 33-bit working width.
  function automatic logic signed [32:0] sext33(input logic [15:0] v);
    return {{17{v[15]}}, v};
  endfunction

  // True when a wide signed result is representable in signed 16 bits.
  function automatic logic fits_s16(input logic signed [32:0] v);
    return (v[32:15] == {18{v[15]}});
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative 16x16 signed multiplier. Works on operand magnitudes with one
// shift-add step per cycle for 16 cycles and applies the sign to the final
// product. 'done' is high during the last iteration, so 'product' is valid
// from the following cycle and holds until the next start.
module seq_multiplier
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [31:0] product
);

  logic [15:0] mag_a;
  logic [15:0] mag_b;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic        neg;
  logic [3:0]  count;
  logic        active;

  // Operand magnitudes; 0x8000 maps to unsigned 32768, which still fits.
  always_comb begin
    mag_a = a[15] ? (~a + 16'd1) : a;
    mag_b = b[15] ? (~b + 16'd1) : b;
  end

  // Shift-add iteration: accumulate the shifted multiplicand on each set bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= {16'd0, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      neg    <= a[15] ^ b[15];
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 4'd1;
      if (count == 4'd15) begin
        active <= 1'b0;
      end
    end
  end

  // Completion flag and signed product.
  always_comb begin
    done    = active && (count == 4'd15);
    product = neg ? (~acc + 32'd1) : acc;
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// Instruction execution stage feeding the LCD controller. Samples an 18-bit
// instruction on a rising edge of 'exec', executes it against a 16x16 signed
// register file, presents the result to the LCD and then waits out a
// hold-off interval so the LCD can finish redrawing.
// Optional build macro CPU_SATURATE_EN: arithmetic ops clamp to the signed
// 16-bit range on overflow instead of wrapping.
module cpu_exec_unit
  import cpu_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               exec,
  input  logic [17:0]        instr,
  output logic               lcd_start,
  output logic [2:0]         lcd_opcode,
  output logic [3:0]         lcd_reg_idx,
  output logic signed [15:0] lcd_value,
  output logic               busy,
  output logic               overflow
);

  state_t      state;
  state_t      next_state;
  logic        exec_prev;
  logic        exec_edge;
  logic [17:0] instr_q;
  logic [15:0] regs [16];
  logic [15:0] opnd_s;
  logic [15:0] opnd_t;
  logic [15:0] opnd_d;
  logic [31:0] hold_cnt;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;

  logic [2:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [15:0] imm7_ext;
  logic [15:0] imm11_ext;

  logic signed [32:0] wide;
  logic               arith;
  logic [15:0]        wb_value;
  logic               wb_ovf;
  logic [3:0]         wb_idx;
  logic               wb_write;

  assign opcode    = instr_q[OPC_MSB:OPC_LSB];
  assign rd        = instr_q[RD_MSB:RD_LSB];
  assign rs        = instr_q[RS_MSB:RS_LSB];
  assign rt        = instr_q[RT_MSB:RT_LSB];
  assign imm7_ext  = {{9{instr_q[IMM7_MSB]}}, instr_q[IMM7_MSB:0]};
  assign imm11_ext = {{5{instr_q[IMM11_MSB]}}, instr_q[IMM11_MSB:0]};
  assign exec_edge = exec && !exec_prev;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; only a fresh rising edge of exec in IDLE starts work.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (exec_edge) next_state = ST_READ;
      ST_READ:    next_state = ST_EXEC;
      ST_EXEC:    if ((opcode != OP_MUL) || mul_done) next_state = ST_WB;
      ST_WB:      next_state = ST_NOTIFY;
      ST_NOTIFY:  next_state = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == 32'(HOLDOFF_CYCLES - 1)) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs and multiplier launch.
  always_comb begin
    busy      = (state != ST_IDLE);
    lcd_start = (state == ST_NOTIFY);
    mul_start = (state == ST_READ) && (opcode == OP_MUL);
  end

  // Previous-cycle exec for edge detection, and instruction capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_prev <= 1'b0;
      instr_q   <= '0;
    end else begin
      exec_prev <= exec;
      if ((state == ST_IDLE) && exec_edge) begin
        instr_q <= instr;
      end
    end
  end

  // Operand fetch from the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opnd_s <= '0;
      opnd_t <= '0;
      opnd_d <= '0;
    end else if (state == ST_READ) begin
      opnd_s <= regs[rs];
      opnd_t <= regs[rt];
      opnd_d <= regs[rd];
    end
  end

  seq_multiplier u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (regs[rs]),
    .b       (regs[rt]),
    .done    (mul_done),
    .product (mul_product)
  );

  // Result, overflow and destination for the write-back cycle.
  always_comb begin
    wide     = '0;
    arith    = 1'b0;
    wb_value = '0;
    wb_ovf   = 1'b0;
    wb_idx   = rd;
    wb_write = 1'b0;
    case (opcode)
      OP_LOAD: begin
        wb_value = imm11_ext;
        wb_write = 1'b1;
      end
      OP_ADD: begin
        wide  = sext33(opnd_s) + sext33(opnd_t);
        arith = 1'b1;
      end
      OP_ADDI: begin
        wide  = sext33(opnd_s) + sext33(imm7_ext);
        arith = 1'b1;
      end
      OP_SUB: begin
        wide  = sext33(opnd_s) - sext33(opnd_t);
        arith = 1'b1;
      end
      OP_SUBI: begin
        wide  = sext33(opnd_s) - sext33(imm7_ext);
        arith = 1'b1;
      end
      OP_MUL: begin
        wide  = {mul_product[31], mul_product};
        arith = 1'b1;
      end
      OP_CLEAR: begin
        wb_idx = 4'd0;
      end
      default: begin
        wb_value = opnd_d;
      end
    endcase
    if (arith) begin
      wb_write = 1'b1;
      wb_ovf   = !fits_s16(wide);
`ifdef CPU_SATURATE_EN
      if (wb_ovf) begin
        wb_value = wide[32] ? 16'h8000 : 16'h7FFF;
      end else begin
        wb_value = wide[15:0];
      end
`else
      wb_value = wide[15:0];
`endif
    end
  end

  // Register file write-back, including the all-register CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_WB) begin
      if (opcode == OP_CLEAR) begin
        for (int i = 0; i < 16; i++) begin
          regs[i] <= '0;
        end
      end else if (wb_write) begin
        regs[rd] <= wb_value;
      end
    end
  end

  // LCD data outputs, held from one write-back to the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_opcode  <= '0;
      lcd_reg_idx <= '0;
      lcd_value   <= '0;
      overflow    <= 1'b0;
    end else if (state == ST_WB) begin
      lcd_opcode  <= opcode;
      lcd_reg_idx <= wb_idx;
      lcd_value   <= wb_value;
      overflow    <= wb_ovf;
    end
  end

  // Hold-off counter: cleared while notifying, counts through HOLDOFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state == ST_NOTIFY) begin
      hold_cnt <= '0;
    end else if (state == ST_HOLDOFF) begin
      hold_cnt <= hold_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Self-checking bench for cpu_exec_unit: a table of instructions with
// hand-computed LCD results, plus directed sequences for exec retriggering
// and reset in the middle of a multiply.
module tb_cpu_exec_unit;

  localparam int HOLD = 8;

`ifdef CPU_SATURATE_EN
  localparam int MUL_NEG_BIG = -32768;
  localparam int ADD_TOP     = 32767;
  localparam int SUB_BOTTOM  = -32768;
  localparam int MUL_POS_BIG = 32767;
`else
  localparam int MUL_NEG_BIG = 5536;
  localparam int ADD_TOP     = -32768;
  localparam int SUB_BOTTOM  = 32767;
  localparam int MUL_POS_BIG = 0;
`endif

  logic               clk;
  logic               reset_n;
  logic               exec;
  logic [17:0]        instr;
  logic               lcd_start;
  logic [2:0]         lcd_opcode;
  logic [3:0]         lcd_reg_idx;
  logic signed [15:0] lcd_value;
  logic               busy;
  logic               overflow;

  int n_checks;
  int n_fail;
  int cap_op;
  int cap_idx;
  int cap_val;
  int cap_ovf;

  typedef struct {
    logic [17:0] instr;
    int          op;
    int          idx;
    int          val;
    int          ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  cpu_exec_unit #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .exec        (exec),
    .instr       (instr),
    .lcd_start   (lcd_start),
    .lcd_opcode  (lcd_opcode),
    .lcd_reg_idx (lcd_reg_idx),
    .lcd_value   (lcd_value),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] f_load(input int rd, input int imm);
    return {3'b000, 4'(rd), 11'(imm)};
  endfunction

  function automatic logic [17:0] f_rrr(input int op, input int rd, input int rs, input int rt);
    return {3'(op), 4'(rd), 4'(rs), 4'(rt), 3'b000};
  endfunction

  function automatic logic [17:0] f_imm(input int op, input int rd, input int rs, input int imm);
    return {3'(op), 4'(rd), 4'(rs), 7'(imm)};
  endfunction

  function automatic logic [17:0] f_dpl(input int rd);
    return {3'b111, 4'(rd), 11'd0};
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Raise exec with a new instruction, measure cycles to lcd_start and
  // cycles from lcd_start until busy drops, capturing the LCD outputs.
  task automatic apply_stimulus(input logic [17:0] in, output int lat, output int fall);
    @(negedge clk);
    instr = in;
    exec  = 1'b1;
    lat   = -1;
    fall  = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (lcd_start) begin
        lat = n;
        break;
      end
    end
    cap_op  = int'(lcd_opcode);
    cap_idx = int'(lcd_reg_idx);
    cap_val = int'(lcd_value);
    cap_ovf = int'(overflow);
    if (lat > 0) begin
      for (int n = 1; n <= 60; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (!busy) begin
          fall = n;
          break;
        end
      end
    end
    exec = 1'b0;
  endtask

  initial begin
    int lat;
    int fall;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    exec     = 1'b0;
    instr    = '0;

    vecs.push_back('{f_load(3, -5),          0,  3,   -5,         0, 4});
    vecs.push_back('{f_load(1, 7),           0,  1,    7,         0, 4});
    vecs.push_back('{f_load(2, 9),           0,  2,    9,         0, 4});
    vecs.push_back('{f_rrr(1, 4, 1, 2),      1,  4,   16,         0, 4});
    vecs.push_back('{f_dpl(4),               7,  4,   16,         0, 4});
    vecs.push_back('{f_load(1, 300),         0,  1,  300,         0, 4});
    vecs.push_back('{f_load(2, -200),        0,  2, -200,         0, 4});
    vecs.push_back('{f_rrr(5, 5, 1, 2),      5,  5, MUL_NEG_BIG,  1, 19});
    vecs.push_back('{f_dpl(5),               7,  5, MUL_NEG_BIG,  0, 4});
    vecs.push_back('{f_rrr(3, 6, 1, 2),      3,  6,  500,         0, 4});
    vecs.push_back('{f_imm(4, 6, 6, 7),      4,  6,  493,         0, 4});
    vecs.push_back('{f_imm(2, 8, 2, -64),    2,  8, -264,         0, 4});
    vecs.push_back('{f_load(9, 1023),        0,  9, 1023,         0, 4});
    vecs.push_back('{f_load(11, 32),         0, 11,   32,         0, 4});
    vecs.push_back('{f_rrr(5, 10, 9, 11),    5, 10, 32736,        0, 19});
    vecs.push_back('{f_imm(2, 10, 10, 31),   2, 10, 32767,        0, 4});
    vecs.push_back('{f_imm(2, 10, 10, 1),    2, 10, ADD_TOP,      1, 4});
    vecs.push_back('{f_load(12, -1024),      0, 12, -1024,        0, 4});
    vecs.push_back('{f_rrr(5, 13, 12, 11),   5, 13, -32768,       0, 19});
    vecs.push_back('{f_imm(4, 13, 13, 1),    4, 13, SUB_BOTTOM,   1, 4});
    vecs.push_back('{f_rrr(5, 15, 12, 12),   5, 15, MUL_POS_BIG,  1, 19});
    vecs.push_back('{f_load(0, -1),          0,  0,   -1,         0, 4});
    vecs.push_back('{f_rrr(1, 0, 0, 0),      1,  0,   -2,         0, 4});
    vecs.push_back('{f_load(7, 1023),        0,  7, 1023,         0, 4});
    vecs.push_back('{f_imm(2, 7, 7, 1),      2,  7, 1024,         0, 4});
    vecs.push_back('{f_rrr(6, 7, 0, 0),      6,  0,    0,         0, 4});
    vecs.push_back('{f_dpl(7),               7,  7,    0,         0, 4});
    vecs.push_back('{f_dpl(4),               7,  4,    0,         0, 4});

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("reset.lcd_start", int'(lcd_start), 0);
    check_output("reset.opcode", int'(lcd_opcode), 0);
    check_output("reset.reg_idx", int'(lcd_reg_idx), 0);
    check_output("reset.value", int'(lcd_value), 0);
    check_output("reset.busy", int'(busy), 0);
    check_output("reset.overflow", int'(overflow), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven instruction vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].instr, lat, fall);
      check_output($sformatf("v%0d.latency", i), lat, vecs[i].lat);
      check_output($sformatf("v%0d.opcode", i), cap_op, vecs[i].op);
      check_output($sformatf("v%0d.reg_idx", i), cap_idx, vecs[i].idx);
      check_output($sformatf("v%0d.value", i), cap_val, vecs[i].val);
      check_output($sformatf("v%0d.overflow", i), cap_ovf, vecs[i].ovf);
      check_output($sformatf("v%0d.busy_fall", i), fall, HOLD + 1);
    end

    // exec held high through an instruction, toggled during HOLDOFF and
    // left high into IDLE: only the first edge may produce a pulse.
    @(negedge clk);
    instr  = f_load(14, 5);
    exec   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (lcd_start) pulses++;
      if (i == 5 || i == 7) exec = 1'b0;
      if (i == 6 || i == 8) exec = 1'b1;
    end
    check_output("hold.pulses", pulses, 1);
    check_output("hold.busy_end", int'(busy), 0);
    exec = 1'b0;
    apply_stimulus(f_dpl(14), lat, fall);
    check_output("hold.dpl_latency", lat, 4);
    check_output("hold.dpl_value", cap_val, 5);

    // Reset asserted in cycle 10 of a multiply.
    apply_stimulus(f_load(5, 77), lat, fall);
    check_output("rst.pre_value", cap_val, 77);
    apply_stimulus(f_load(1, 300), lat, fall);
    apply_stimulus(f_load(2, -200), lat, fall);
    @(negedge clk);
    instr = f_rrr(5, 5, 1, 2);
    exec  = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check_output("rst.busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_output("rst.busy", int'(busy), 0);
    check_output("rst.lcd_start", int'(lcd_start), 0);
    check_output("rst.opcode", int'(lcd_opcode), 0);
    check_output("rst.reg_idx", int'(lcd_reg_idx), 0);
    check_output("rst.value", int'(lcd_value), 0);
    check_output("rst.overflow", int'(overflow), 0);
    exec = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(f_dpl(5), lat, fall);
    check_output("rst.dpl5_latency", lat, 4);
    check_output("rst.dpl5_value", cap_val, 0);
    apply_stimulus(f_dpl(1), lat, fall);
    check_output("rst.dpl1_value", cap_val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
